// File: rtl/gpio_in_cond_if.sv
// Bundle of pad samples, conditioning controls and conditioned outputs
// that passes between the GPIO core and the input-conditioning stage.
interface gpio_in_cond_if #(
  parameter int WIDTH = 32,
  parameter int DEB_W = 8
);
  logic [WIDTH-1:0] in_pad_i;
  logic [DEB_W-1:0] deb_limit;
  logic [WIDTH-1:0] inte;
  logic [WIDTH-1:0] ptrig;
  logic             ie;
  logic [WIDTH-1:0] ints_clr;
  logic [WIDTH-1:0] in_sync_o;
  logic [WIDTH-1:0] in_deb_o;
  logic [WIDTH-1:0] ints_o;
  logic             inta_o;

  modport master (
    output in_pad_i, deb_limit, inte, ptrig, ie, ints_clr,
    input  in_sync_o, in_deb_o, ints_o, inta_o
  );

  modport slave (
    input  in_pad_i, deb_limit, inte, ptrig, ie, ints_clr,
    output in_sync_o, in_deb_o, ints_o, inta_o
  );
endinterface

// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: per-bit synchroniser, debounce, edge detect,
// sticky interrupt status and a combined interrupt request.
module gpio_in_cond #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 8
) (
  input logic           wb_clk_i,
  input logic           wb_rst_i,
  gpio_in_cond_if.slave bus
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][DEB_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]                  deb_q, deb_d;
  logic [WIDTH-1:0]                  deb_prev_q;
  logic [WIDTH-1:0]                  ints_q, ints_d;
  logic [WIDTH-1:0]                  in_sync_s, rise_s, fall_s, evt_s;
  logic [DEB_W-1:0]                  lim_m1_s;

  assign in_sync_s = sync_q[SYNC_STAGES-1];

  // A limit of 0 behaves like 1, so both give a terminal count of 0.
  assign lim_m1_s = (bus.deb_limit == {DEB_W{1'b0}}) ? {DEB_W{1'b0}}
                                                     : bus.deb_limit - DEB_W'(1);

  always_comb begin
    sync_d[0] = bus.in_pad_i;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_sync_s[i] == deb_q[i]) begin
        cnt_d[i] = {DEB_W{1'b0}};
      end else if (cnt_q[i] == lim_m1_s) begin
        deb_d[i] = in_sync_s[i];
        cnt_d[i] = {DEB_W{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + DEB_W'(1);
      end
    end
  end

  // A new event takes priority over a clear arriving in the same cycle.
  always_comb begin
    rise_s = deb_q & ~deb_prev_q;
    fall_s = ~deb_q & deb_prev_q;
    evt_s  = bus.inte & ((bus.ptrig & rise_s) | (~bus.ptrig & fall_s));
    ints_d = evt_s | (ints_q & ~bus.ints_clr);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      deb_q      <= {WIDTH{1'b0}};
      deb_prev_q <= {WIDTH{1'b0}};
      ints_q     <= {WIDTH{1'b0}};
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      ints_q     <= ints_d;
    end
  end

  assign bus.in_sync_o = in_sync_s;
  assign bus.in_deb_o  = deb_q;
  assign bus.ints_o    = ints_q;
  assign bus.inta_o    = bus.ie & (|ints_q);

endmodule

// File: tb/tb_gpio_in_cond.sv
// Directed self-checking bench for gpio_in_cond with hand-computed expectations.
module tb_gpio_in_cond;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  gpio_in_cond_if #(.WIDTH(32), .DEB_W(8)) bus ();

  gpio_in_cond #(.WIDTH(32), .SYNC_STAGES(2), .DEB_W(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst              = 1'b1;
    bus.in_pad_i     = 32'hFFFF_FFFF;
    bus.deb_limit    = 8'd1;
    bus.inte         = 32'h0000_0000;
    bus.ptrig        = 32'h0000_0000;
    bus.ie           = 1'b0;
    bus.ints_clr     = 32'h0000_0000;

    // Reset held with pad high
    tick(3);
    chk("rst_deb",  bus.in_deb_o,  32'h0000_0000);
    chk("rst_sync", bus.in_sync_o, 32'h0000_0000);
    chk("rst_ints", bus.ints_o,    32'h0000_0000);
    chk("rst_inta", {31'd0, bus.inta_o}, 32'd0);
    rst = 1'b0;
    tick(2);
    chk("rel2_sync", bus.in_sync_o, 32'hFFFF_FFFF);
    chk("rel2_deb",  bus.in_deb_o,  32'h0000_0000);
    tick(1);
    chk("rel3_deb",  bus.in_deb_o,  32'hFFFF_FFFF);
    tick(1);
    chk("rel4_ints", bus.ints_o,    32'h0000_0000);

    // Return pad low, no interrupts enabled
    bus.in_pad_i = 32'h0000_0000;
    tick(5);
    chk("idle_deb",  bus.in_deb_o,  32'h0000_0000);
    chk("idle_ints", bus.ints_o,    32'h0000_0000);

    // Latency with deb_limit = 4, rising edge on bit 0
    bus.deb_limit = 8'd4;
    bus.inte      = 32'h0000_0001;
    bus.ptrig     = 32'h0000_0001;
    bus.ie        = 1'b1;
    bus.in_pad_i[0] = 1'b1;
    tick(1);
    chk("lat_sync_c1", bus.in_sync_o, 32'h0000_0000);
    tick(1);
    chk("lat_sync_c2", bus.in_sync_o, 32'h0000_0001);
    tick(3);
    chk("lat_deb_c5",  bus.in_deb_o,  32'h0000_0000);
    tick(1);
    chk("lat_deb_c6",  bus.in_deb_o,  32'h0000_0001);
    chk("lat_ints_c6", bus.ints_o,    32'h0000_0000);
    tick(1);
    chk("lat_ints_c7", bus.ints_o,    32'h0000_0001);
    chk("lat_inta_c7", {31'd0, bus.inta_o}, 32'd1);

    // Clear bit 0, then its falling edge must not set status
    bus.ints_clr = 32'h0000_0001;
    tick(1);
    bus.ints_clr = 32'h0000_0000;
    chk("clr0_ints", bus.ints_o, 32'h0000_0000);
    chk("clr0_inta", {31'd0, bus.inta_o}, 32'd0);
    bus.in_pad_i[0] = 1'b0;
    tick(8);
    chk("fall0_deb",  bus.in_deb_o, 32'h0000_0000);
    chk("fall0_ints", bus.ints_o,   32'h0000_0000);

    // Glitch rejection on bit 5: 3-cycle pulse never passes
    bus.in_pad_i[5] = 1'b1;
    tick(3);
    bus.in_pad_i[5] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("glitch3_deb", bus.in_deb_o, 32'h0000_0000);
    end
    chk("glitch3_ints", bus.ints_o, 32'h0000_0000);

    // 4-cycle pulse on bit 5 is high on in_deb_o after edges 6..9
    bus.in_pad_i[5] = 1'b1;
    tick(4);
    bus.in_pad_i[5] = 1'b0;
    chk("pulse4_deb_c4", bus.in_deb_o, 32'h0000_0000);
    for (int c = 5; c <= 11; c++) begin
      tick(1);
      chk("pulse4_deb", bus.in_deb_o, ((c >= 6) && (c <= 9)) ? 32'h0000_0020 : 32'h0000_0000);
    end
    chk("pulse4_ints", bus.ints_o, 32'h0000_0000);

    // Falling-edge select on bit 3
    bus.inte  = 32'h0000_0008;
    bus.ptrig = 32'h0000_0000;
    bus.in_pad_i[3] = 1'b1;
    tick(6);
    chk("fsel_rise_deb",  bus.in_deb_o, 32'h0000_0008);
    tick(1);
    chk("fsel_rise_ints", bus.ints_o,   32'h0000_0000);
    bus.in_pad_i[3] = 1'b0;
    tick(5);
    chk("fsel_c5_deb",    bus.in_deb_o, 32'h0000_0008);
    tick(1);
    chk("fsel_c6_deb",    bus.in_deb_o, 32'h0000_0000);
    chk("fsel_c6_ints",   bus.ints_o,   32'h0000_0000);
    tick(1);
    chk("fsel_c7_ints",   bus.ints_o,   32'h0000_0008);
    bus.ints_clr = 32'h0000_0008;
    tick(1);
    bus.ints_clr = 32'h0000_0000;
    chk("fsel_clr_ints",  bus.ints_o,   32'h0000_0000);

    // Bit 7: set, clear, then clear colliding with a new event
    bus.inte  = 32'h0000_0080;
    bus.ptrig = 32'h0000_0080;
    bus.in_pad_i[7] = 1'b1;
    tick(7);
    chk("b7_set_ints", bus.ints_o, 32'h0000_0080);
    chk("b7_set_inta", {31'd0, bus.inta_o}, 32'd1);
    bus.ints_clr = 32'h0000_0080;
    tick(1);
    bus.ints_clr = 32'h0000_0000;
    chk("b7_clr_ints", bus.ints_o, 32'h0000_0000);
    bus.in_pad_i[7] = 1'b0;
    tick(8);
    chk("b7_low_ints", bus.ints_o,   32'h0000_0000);
    chk("b7_low_deb",  bus.in_deb_o, 32'h0000_0000);
    bus.in_pad_i[7] = 1'b1;
    tick(6);
    chk("b7_rise_deb", bus.in_deb_o, 32'h0000_0080);
    bus.ints_clr = 32'h0000_0080;
    bus.ie       = 1'b0;
    tick(1);
    bus.ints_clr = 32'h0000_0000;
    chk("b7_coll_ints", bus.ints_o, 32'h0000_0080);
    chk("b7_coll_inta", {31'd0, bus.inta_o}, 32'd0);

    // Reset mid-count with deb_limit = 200 on bit 9
    bus.deb_limit = 8'd200;
    bus.inte      = 32'h0000_0280;
    bus.ptrig     = 32'h0000_0280;
    bus.in_pad_i[9] = 1'b1;
    tick(100);
    chk("mid_deb", bus.in_deb_o, 32'h0000_0080);
    rst = 1'b1;
    #1;
    chk("mid_rst_deb",  bus.in_deb_o, 32'h0000_0000);
    chk("mid_rst_ints", bus.ints_o,   32'h0000_0000);
    tick(1);
    rst = 1'b0;
    tick(201);
    chk("post_c201_deb", bus.in_deb_o, 32'h0000_0000);
    tick(1);
    chk("post_c202_deb", bus.in_deb_o, 32'h0000_0280);
    tick(1);
    chk("post_ints",     bus.ints_o,   32'h0000_0280);
    chk("post_inta_ie0", {31'd0, bus.inta_o}, 32'd0);
    bus.ie = 1'b1;
    #1;
    chk("post_inta_ie1", {31'd0, bus.inta_o}, 32'd1);

    // deb_limit = 0 behaves as 1
    bus.deb_limit   = 8'd0;
    bus.in_pad_i[9] = 1'b0;
    tick(2);
    chk("lim0_c2_deb", bus.in_deb_o, 32'h0000_0280);
    tick(1);
    chk("lim0_c3_deb", bus.in_deb_o, 32'h0000_0080);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
